// File: rtl/fft_input_loader.sv
// Ping-pong input loader for a streaming FFT: accepts LANES complex samples per beat
// and writes them to one of two banks in natural or bit-reversed point order.
// The consumer handshake port is bank_release because "release" is a reserved word.
module fft_input_loader #(
    parameter int N             = 32,
    parameter int word_size     = 16,
    parameter int LANES         = 2,
    parameter int address_width = $clog2(N)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             en,
    input  logic                             in_valid,
    input  logic [LANES*2*word_size-1:0]     samples,
    input  logic                             bitrev_en,
    input  logic                             bank_release,
    output logic                             in_ready,
    output logic                             wr_en,
    output logic                             wr_bank,
    output logic [LANES*address_width-1:0]   wr_addr,
    output logic [LANES*2*word_size-1:0]     wr_data,
    output logic                             busy,
    output logic                             frame_done,
    output logic                             o_input_valid,
    output logic                             rd_bank
);

    localparam int AW = address_width;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LOAD      = 2'd1;
    localparam logic [1:0] WAIT_BANK = 2'd2;

    localparam logic [AW-1:0] LAST_CNT = AW'(N - LANES);

    logic [AW-1:0]          cnt;
    logic                   wb;
    logic                   mode;
    logic [1:0]             full;
    logic [1:0]             state;
    logic                   accept;
    logic                   last_beat;
    logic                   cur_mode;
    logic [1:0]             set_mask;
    logic [1:0]             clr_mask;
    logic [1:0]             full_next;
    logic [LANES*AW-1:0]    next_addr;

    function automatic logic [AW-1:0] bit_rev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
        return r;
    endfunction

    assign in_ready      = en & ~reset & ~full[wb];
    assign accept        = in_valid & in_ready;
    assign last_beat     = (cnt == LAST_CNT);
    // The addressing mode is sampled on a frame's first beat and frozen for the rest.
    assign cur_mode      = (cnt == '0) ? bitrev_en : mode;
    assign busy          = (state == LOAD);
    assign o_input_valid = full[rd_bank];

    // A completed bank is marked full on the cycle after its final write is presented.
    assign set_mask  = frame_done ? (2'b01 << wr_bank) : 2'b00;
    assign clr_mask  = (bank_release && full[rd_bank]) ? (2'b01 << rd_bank) : 2'b00;
    assign full_next = (full & ~clr_mask) | set_mask;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        next_addr = '0;
        for (int k = 0; k < LANES; k++) begin
            logic [AW-1:0] a;
            a = cnt + AW'(k);
            next_addr[k*AW +: AW] = cur_mode ? bit_rev(a) : a;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            wb         <= 1'b0;
            mode       <= 1'b0;
            full       <= 2'b00;
            rd_bank    <= 1'b0;
            state      <= IDLE;
            wr_en      <= 1'b0;
            wr_bank    <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
        end else begin
            wr_en      <= accept;
            frame_done <= accept & last_beat;
            if (accept) begin
                wr_bank <= wb;
                wr_addr <= next_addr;
                wr_data <= samples;
                cnt     <= last_beat ? '0 : cnt + AW'(LANES);
                if (cnt == '0) mode <= bitrev_en;
                if (last_beat) wb <= ~wb;
            end

            full <= full_next;
            if (clr_mask != 2'b00) rd_bank <= ~rd_bank;

            case (state)
                IDLE, LOAD: begin
                    if (accept) begin
                        if (!last_beat)         state <= LOAD;
                        else if (full_next[!wb]) state <= WAIT_BANK;
                        else                    state <= IDLE;
                    end
                end
                WAIT_BANK: if (!full[wb]) state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

endmodule
